// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
//   Shared definitions for the ALU fetch/decode/issue sequencer:
//   opcode constants, the sequencer state type, the decoded-instruction
//   record and the branch-offset lookup table.
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

  // ALU opcodes 0x0..0x9 write the register file; 0xA/0xB are branches.
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LAST_WR = 4'h9;
  localparam logic [3:0] OP_BNZL  = 4'hA;
  localparam logic [3:0] OP_BNZR  = 4'hB;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_RSVD  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_t;

  // Fields and class flags of one 9-bit instruction.
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] ra;        // {1'b0, instr[4:3]}
    logic [2:0] rb;        // instr[2:0] as register address
    logic [2:0] imm;       // instr[2:0] as immediate / LUT index
    logic       alu_wr;    // opcodes 0x0..0x9 write the register file
    logic       is_bnzl;
    logic       is_bnzr;
    logic       is_load;
    logic       is_store;
    logic       is_halt;
  } decode_t;

  // Branch-offset table indexed by Im; element [0] is the least significant.
  localparam logic [7:0][15:0] BR_LUT = {16'd32, 16'd16, 16'd8, 16'd6,
                                         16'd4,  16'd3,  16'd2, 16'd1};

endpackage

// File: rtl/alu_seq_decode.sv
// ---------------------------------------------------------------------------
// alu_seq_decode
//   Pure combinational instruction decoder for alu_sequencer.
//   Ports:
//     instr_i [8:0]  raw instruction word from the ROM
//     dec_o          decoded fields and class flags (decode_t)
// ---------------------------------------------------------------------------
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [8:0] instr_i,
  output decode_t    dec_o
);

  logic [3:0] opcode;

  assign opcode = instr_i[8:5];

  always_comb begin
    dec_o          = '0;
    dec_o.opcode   = opcode;
    dec_o.ra       = {1'b0, instr_i[4:3]};
    dec_o.rb       = instr_i[2:0];
    dec_o.imm      = instr_i[2:0];
    dec_o.alu_wr   = (opcode <= OP_LAST_WR);
    dec_o.is_bnzl  = (opcode == OP_BNZL);
    dec_o.is_bnzr  = (opcode == OP_BNZR);
    dec_o.is_load  = (opcode == OP_LOAD);
    dec_o.is_store = (opcode == OP_STORE);
    dec_o.is_halt  = (opcode == OP_HALT);
  end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Multi-cycle fetch/decode/issue controller for a combinational ALU.
//   Fetches 9-bit instructions from a synchronous ROM, drives ALU opcode /
//   immediate and register-file addresses, sequences LOAD/STORE through a
//   req/ack data-memory handshake and updates the PC (incl. LUT branches).
//
//   Optional feature macro: ALU_SEQ_PERF_CNT_EN adds the RetireCnt output,
//   a saturating count of retired instructions cleared by reset and Start.
//
//   Ports:
//     Clk          rising-edge clock
//     Reset        asynchronous active-low reset
//     Start        run from PC 0 (only in IDLE or HALTED)
//     InstrAddr    ROM address, always equal to the PC register
//     Instruction  ROM data, valid one cycle after InstrAddr changes
//     RegAddrA/B   register-file read addresses (A is also write destination)
//     RegWrEn      one-cycle register write strobe
//     RegWrSel     write source: 0 = ALU result, 1 = memory read data
//     AluOp/AluIm  ALU opcode and immediate
//     AluBranch    ALU branch flag, sampled during EXEC of BNZL/BNZR
//     MemReq       data-memory request, held until MemAck
//     MemWrEn      1 = store, 0 = load (valid with MemReq)
//     MemAck       data-memory completion (ignored outside MEM)
//     Done         program halted
//     RetireCnt    retired-instruction count (ALU_SEQ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PW    = 10,
  parameter int LUT_W = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic [PW-1:0] InstrAddr,
  input  logic [8:0]    Instruction,
  output logic [2:0]    RegAddrA,
  output logic [2:0]    RegAddrB,
  output logic          RegWrEn,
  output logic          RegWrSel,
  output logic [3:0]    AluOp,
  output logic [2:0]    AluIm,
  input  logic          AluBranch,
  output logic          MemReq,
  output logic          MemWrEn,
  input  logic          MemAck,
  output logic          Done
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]   RetireCnt
`endif
);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          done_q;
  logic          memreq_q;

  decode_t       dec;
  logic [LUT_W-1:0] lut_raw;
  logic [PW-1:0] br_off;
  logic [PW-1:0] pc_inc;
  logic          in_op;
  logic          start_ok;
  logic          load_ack;

  alu_seq_decode u_decode (
    .instr_i (Instruction),
    .dec_o   (dec)
  );

  // LUT entries are zero-extended to the PC width; PC math wraps mod 2^PW.
  assign lut_raw = BR_LUT[dec.imm][LUT_W-1:0];
  assign br_off  = PW'(lut_raw);
  assign pc_inc  = pc_q + PW'(1);

  assign in_op    = (state_q == ST_EXEC) || (state_q == ST_MEM);
  assign start_ok = Start && ((state_q == ST_IDLE) || (state_q == ST_HALTED));
  assign load_ack = (state_q == ST_MEM) && dec.is_load && MemAck;

  // Next-state and PC update. The PC only moves when leaving EXEC or MEM,
  // which keeps the ROM output stable for the whole instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec.is_load || dec.is_store) begin
          state_d = ST_MEM;
        end else if (dec.is_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
          if (dec.is_bnzl && AluBranch)      pc_d = pc_q - br_off;
          else if (dec.is_bnzr && AluBranch) pc_d = pc_q + br_off;
          else                               pc_d = pc_inc;
        end
      end
      ST_MEM: begin
        if (MemAck) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      done_q   <= 1'b0;
      memreq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      done_q   <= (state_d == ST_HALTED);
      memreq_q <= (state_d == ST_MEM);
    end
  end

  // Decoded fields are only presented while an instruction is in flight.
  assign InstrAddr = pc_q;
  assign AluOp     = in_op ? dec.opcode : 4'h0;
  assign AluIm     = in_op ? dec.imm    : 3'h0;
  assign RegAddrA  = in_op ? dec.ra     : 3'h0;
  assign RegAddrB  = in_op ? dec.rb     : 3'h0;
  assign RegWrEn   = ((state_q == ST_EXEC) && dec.alu_wr) || load_ack;
  assign RegWrSel  = load_ack;
  assign MemReq    = memreq_q;
  assign MemWrEn   = memreq_q && dec.is_store;
  assign Done      = done_q;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] retire_q;
  logic        retire_ev;

  // Retire on EXEC exit to FETCH or HALTED, and on the MEM ack cycle.
  assign retire_ev = ((state_q == ST_EXEC) && !dec.is_load && !dec.is_store) ||
                     ((state_q == ST_MEM) && MemAck);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      retire_q <= '0;
    end else if (start_ok) begin
      retire_q <= '0;
    end else if (retire_ev && (retire_q != 16'hFFFF)) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign RetireCnt = retire_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int PW = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [PW-1:0] InstrAddr;
  logic [8:0]    Instruction = '0;
  logic [2:0]    RegAddrA, RegAddrB;
  logic          RegWrEn, RegWrSel;
  logic [3:0]    AluOp;
  logic [2:0]    AluIm;
  logic          AluBranch = 1'b0;
  logic          MemReq, MemWrEn;
  logic          MemAck = 1'b0;
  logic          Done;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0]   RetireCnt;
`endif

  alu_sequencer #(.PW(PW), .LUT_W(10)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .InstrAddr   (InstrAddr),
    .Instruction (Instruction),
    .RegAddrA    (RegAddrA),
    .RegAddrB    (RegAddrB),
    .RegWrEn     (RegWrEn),
    .RegWrSel    (RegWrSel),
    .AluOp       (AluOp),
    .AluIm       (AluIm),
    .AluBranch   (AluBranch),
    .MemReq      (MemReq),
    .MemWrEn     (MemWrEn),
    .MemAck      (MemAck),
    .Done        (Done)
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    .RetireCnt   (RetireCnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Synchronous instruction ROM.
  logic [8:0] rom [0:1023];
  always @(posedge Clk) Instruction <= rom[InstrAddr];

  int memreq_cnt = 0;
  always @(negedge Clk) if (MemReq) memreq_cnt = memreq_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Instruction-level reference model state.
  logic [PW-1:0] pc_m;
  int            retired_m;
  int            br_force  = -1;
  int            dly_force = -1;
  int            lut_m [8] = '{1, 2, 3, 4, 6, 8, 16, 32};

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Entered one step after the edge that starts a FETCH cycle; returns at
  // the same point of the next FETCH cycle, or inside HALTED.
  task automatic exec_instr(output bit halted);
    logic [8:0] ins;
    logic [3:0] op;
    bit         br;
    int         dly;
    halted = 1'b0;
    AluBranch = 1'($urandom); MemAck = 1'($urandom); Start = 1'($urandom);
    #1;
    chk("fetch_addr", 32'(InstrAddr), 32'(pc_m));
    chk("fetch_idle", 32'({RegWrEn, MemReq, AluOp, Done}), 32'd0);
    cyc();
    ins = rom[pc_m];
    op  = ins[8:5];
    br  = (br_force < 0) ? 1'($urandom) : 1'(br_force);
    AluBranch = br; MemAck = 1'($urandom); Start = 1'($urandom);
    #1;
    chk("exec_op",  32'(AluOp),    32'(op));
    chk("exec_im",  32'(AluIm),    32'(ins[2:0]));
    chk("exec_ra",  32'(RegAddrA), 32'({1'b0, ins[4:3]}));
    chk("exec_rb",  32'(RegAddrB), 32'(ins[2:0]));
    chk("exec_wr",  32'({RegWrEn, RegWrSel}), 32'({(op <= 4'h9), 1'b0}));
    chk("exec_req", 32'(MemReq), 32'd0);
    if (op == 4'hC || op == 4'hD) begin
      dly = (dly_force < 0) ? $urandom_range(0, 3) : dly_force;
      for (int k = 0; k <= dly; k++) begin
        cyc();
        AluBranch = 1'($urandom); MemAck = (k == dly); Start = 1'($urandom);
        #1;
        chk("mem_req",  32'(MemReq),  32'd1);
        chk("mem_we",   32'(MemWrEn), 32'(op == 4'hD));
        chk("mem_wr",   32'({RegWrEn, RegWrSel}),
            32'({2{(op == 4'hC) && (k == dly)}}));
        chk("mem_regs", 32'({RegAddrA, RegAddrB}), 32'({1'b0, ins[4:3], ins[2:0]}));
        chk("mem_addr", 32'(InstrAddr), 32'(pc_m));
      end
      pc_m = pc_m + PW'(1);
      retired_m++;
    end else if (op == 4'hF) begin
      retired_m++;
      Start = 1'b0;
      cyc();
      AluBranch = 1'b0; MemAck = 1'($urandom);
      #1;
      chk("halt_done", 32'(Done), 32'd1);
      chk("halt_addr", 32'(InstrAddr), 32'(pc_m));
      halted = 1'b1;
      return;
    end else begin
      if (op == 4'hA && br)      pc_m = pc_m - PW'(lut_m[ins[2:0]]);
      else if (op == 4'hB && br) pc_m = pc_m + PW'(lut_m[ins[2:0]]);
      else                       pc_m = pc_m + PW'(1);
      retired_m++;
    end
    Start = 1'b0;
    cyc();
  endtask

  // Must be called while the DUT is in IDLE or HALTED.
  task automatic run_prog(input int maxn, output bit halted);
    Start = 1'b1; MemAck = 1'b0; AluBranch = 1'b0;
    cyc();
    Start = 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("cnt_clear", 32'(RetireCnt), 32'd0);
`endif
    pc_m = '0;
    retired_m = 0;
    halted = 1'b0;
    for (int i = 0; i < maxn && !halted; i++) exec_instr(halted);
`ifdef ALU_SEQ_PERF_CNT_EN
    if (halted) chk("cnt_halt", 32'(RetireCnt), 32'(retired_m));
`endif
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0; Start = 1'b0; MemAck = 1'b0; AluBranch = 1'b0;
    #1;
    chk(tag, 32'({InstrAddr, RegAddrA, RegAddrB, RegWrEn, RegWrSel, AluOp,
                  AluIm, MemReq, MemWrEn, Done}), 32'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk({tag, "_cnt"}, 32'(RetireCnt), 32'd0);
`endif
    #1;
    Reset = 1'b1;
    cyc();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit h;
    int c0;
    fill_rand();
    repeat (2) cyc();
    do_reset("rst_state");

    // Reset while a LOAD waits in MEM.
    rom[0] = {4'hC, 2'b10, 3'd5};
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    cyc();
    #1;
    chk("pre_rst_req", 32'(MemReq), 32'd1);
    do_reset("rst_mid_mem");

    // ADD r1,r2 ; ADDI r1,3 ; HALT, then re-run from HALTED.
    rom[0] = {4'h0, 2'b01, 3'd2};
    rom[1] = {4'h1, 2'b01, 3'd3};
    rom[2] = {4'hF, 5'd0};
    run_prog(10, h);
    chk("prog1_halted", 32'(h), 32'd1);
    cyc();
    chk("prog1_done_hold", 32'(Done), 32'd1);
    run_prog(10, h);
    chk("prog1_rerun", 32'(h), 32'd1);

    // 5 ALU ops + STORE + HALT.
    for (int i = 0; i < 5; i++) rom[i] = {4'($urandom_range(0, 9)), 5'($urandom)};
    rom[5] = {4'hD, 2'b01, 3'd6};
    rom[6] = {4'hF, 5'd0};
    run_prog(10, h);
    chk("perf_halted", 32'(h), 32'd1);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("perf_cnt7", 32'(RetireCnt), 32'd7);
`endif
    do_reset("rst_b1");

    // BNZR Im=5 at PC 10, taken and not taken.
    for (int i = 0; i < 10; i++) rom[i] = {4'h1, 5'($urandom)};
    rom[10] = {4'hB, 2'b00, 3'd5};
    br_force = 1;
    run_prog(11, h);
    chk("bnzr_taken", 32'(InstrAddr), 32'd18);
    do_reset("rst_b2");
    br_force = 0;
    run_prog(11, h);
    chk("bnzr_not_taken", 32'(InstrAddr), 32'd11);
    do_reset("rst_b3");

    // BNZL Im=1 at PC 0 wraps below zero, then the PC wraps past the top.
    rom[0] = {4'hA, 2'b00, 3'd1};
    rom[10'h3FE] = {4'h0, 5'd3};
    rom[10'h3FF] = {4'h0, 5'd4};
    br_force = 1;
    run_prog(1, h);
    chk("bnzl_wrap", 32'(InstrAddr), 32'h3FE);
    exec_instr(h);
    exec_instr(h);
    chk("pc_wrap_top", 32'(InstrAddr), 32'd0);
    br_force = -1;
    do_reset("rst_b4");

    // LOAD with the ack three cycles late.
    rom[0] = {4'hC, 2'b10, 3'd5};
    dly_force = 3;
    c0 = memreq_cnt;
    run_prog(1, h);
    chk("load_req_cycles", 32'(memreq_cnt - c0), 32'd4);
    chk("load_pc", 32'(InstrAddr), 32'd1);
    do_reset("rst_b5");

    // STORE acked in its first MEM cycle.
    rom[0] = {4'hD, 2'b01, 3'd6};
    dly_force = 0;
    c0 = memreq_cnt;
    run_prog(1, h);
    chk("store_req_cycles", 32'(memreq_cnt - c0), 32'd1);
    chk("store_pc", 32'(InstrAddr), 32'd1);
    dly_force = -1;
    do_reset("rst_b6");

    // Random programs.
    for (int p = 0; p < 10; p++) begin
      fill_rand();
      run_prog(80, h);
      if (!h) do_reset("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
